// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding producer: holds the EX/MEM and MEM/WB pipeline registers,
// selects forwarding sources for EX operands and detects load-use hazards.
module fwd_hazard_unit #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_ex_valid,
    input  logic [RA_W-1:0] i_ex_rs1,
    input  logic [RA_W-1:0] i_ex_rs2,
    input  logic [RA_W-1:0] i_ex_rd,
    input  logic            i_ex_reg_write,
    input  logic            i_ex_mem_read,
    input  logic [XLEN-1:0] i_ex_alu_result,
    input  logic [RA_W-1:0] i_id_rs1,
    input  logic [RA_W-1:0] i_id_rs2,
    input  logic            i_id_use_rs1,
    input  logic            i_id_use_rs2,
    input  logic [XLEN-1:0] i_mem_load_data,
    input  logic            i_flush,
    output logic [1:0]      o_forward_a,
    output logic [1:0]      o_forward_b,
    output logic [XLEN-1:0] o_forwarding_ex_mem,
    output logic [XLEN-1:0] o_forwarding_mem_wb,
    output logic            o_stall,
    output logic            o_bubble,
    output logic [RA_W-1:0] o_wb_rd,
    output logic            o_wb_we,
    output logic [XLEN-1:0] o_wb_data,
    output logic [CNT_W-1:0] o_stall_cnt
);

    logic [RA_W-1:0]  r_exm_rd;
    logic             r_exm_we;
    logic             r_exm_mem_read;
    logic [XLEN-1:0]  r_exm_result;
    logic [RA_W-1:0]  r_mwb_rd;
    logic             r_mwb_we;
    logic [XLEN-1:0]  r_mwb_data;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [RA_W-1:0]  w_ex_rs [2];
    logic [1:0]       w_fwd   [2];
    logic             w_hz;
    logic             w_stall;

    assign w_ex_rs[0] = i_ex_rs1;
    assign w_ex_rs[1] = i_ex_rs2;

    // EX/MEM wins over MEM/WB; a load still in EX/MEM has no data yet and never forwards.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        assign w_fwd[gi] =
            (r_exm_we && (r_exm_rd != '0) && (r_exm_rd == w_ex_rs[gi]) && !r_exm_mem_read) ? 2'b10 :
            (r_mwb_we && (r_mwb_rd != '0) && (r_mwb_rd == w_ex_rs[gi]))                    ? 2'b01 :
                                                                                             2'b00;
    end

    assign w_hz = i_ex_valid && i_ex_mem_read && (i_ex_rd != '0) &&
                  ((i_id_use_rs1 && (i_id_rs1 == i_ex_rd)) ||
                   (i_id_use_rs2 && (i_id_rs2 == i_ex_rd)));

    // Held low during reset so every output reads zero while rst_n is asserted.
    assign w_stall = w_hz && !i_flush && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exm_rd       <= '0;
            r_exm_we       <= 1'b0;
            r_exm_mem_read <= 1'b0;
            r_exm_result   <= '0;
            r_mwb_rd       <= '0;
            r_mwb_we       <= 1'b0;
            r_mwb_data     <= '0;
            r_stall_cnt    <= '0;
        end else begin
            r_exm_rd       <= i_ex_rd;
            r_exm_we       <= i_ex_reg_write && i_ex_valid;
            r_exm_mem_read <= i_ex_mem_read && i_ex_valid;
            r_exm_result   <= i_ex_alu_result;
            r_mwb_rd       <= r_exm_rd;
            r_mwb_we       <= r_exm_we;
            r_mwb_data     <= r_exm_mem_read ? i_mem_load_data : r_exm_result;
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign o_forward_a         = w_fwd[0];
    assign o_forward_b         = w_fwd[1];
    assign o_forwarding_ex_mem = r_exm_result;
    assign o_forwarding_mem_wb = r_mwb_data;
    assign o_stall             = w_stall;
    assign o_bubble            = w_stall;
    assign o_wb_rd             = r_mwb_rd;
    assign o_wb_we             = r_mwb_we;
    assign o_wb_data           = r_mwb_data;
    assign o_stall_cnt         = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fwd_hazard_unit;

    localparam int CW = 4;

    localparam logic [5:0] M_FWD = 6'b000001;
    localparam logic [5:0] M_EXM = 6'b000010;
    localparam logic [5:0] M_MWB = 6'b000100;
    localparam logic [5:0] M_WB  = 6'b001000;
    localparam logic [5:0] M_STL = 6'b010000;
    localparam logic [5:0] M_CNT = 6'b100000;
    localparam logic [5:0] M_ALL = 6'b111111;

    logic        clk;
    logic        rst_n;
    logic        ex_valid, ex_reg_write, ex_mem_read, flush;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd, id_rs1, id_rs2;
    logic        id_use_rs1, id_use_rs2;
    logic [31:0] ex_alu_result, mem_load_data;
    logic [1:0]  fa, fb;
    logic [31:0] fwd_exm, fwd_mwb, wb_data;
    logic        stall, bubble, wb_we;
    logic [4:0]  wb_rd;
    logic [CW-1:0] stall_cnt;

    typedef struct {
        string       name;
        int          cyc;
        logic [5:0]  mask;
        logic [1:0]  fa, fb;
        logic [31:0] exm, mwb;
        logic [4:0]  wb_rd;
        logic        wb_we;
        logic [31:0] wb_data;
        logic        stall;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    fwd_hazard_unit #(.XLEN(32), .RA_W(5), .CNT_W(CW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_ex_valid          (ex_valid),
        .i_ex_rs1            (ex_rs1),
        .i_ex_rs2            (ex_rs2),
        .i_ex_rd             (ex_rd),
        .i_ex_reg_write      (ex_reg_write),
        .i_ex_mem_read       (ex_mem_read),
        .i_ex_alu_result     (ex_alu_result),
        .i_id_rs1            (id_rs1),
        .i_id_rs2            (id_rs2),
        .i_id_use_rs1        (id_use_rs1),
        .i_id_use_rs2        (id_use_rs2),
        .i_mem_load_data     (mem_load_data),
        .i_flush             (flush),
        .o_forward_a         (fa),
        .o_forward_b         (fb),
        .o_forwarding_ex_mem (fwd_exm),
        .o_forwarding_mem_wb (fwd_mwb),
        .o_stall             (stall),
        .o_bubble            (bubble),
        .o_wb_rd             (wb_rd),
        .o_wb_we             (wb_we),
        .o_wb_data           (wb_data),
        .o_stall_cnt         (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic drive(input logic v, input logic [4:0] rd, rs1, rs2,
                         input logic we, mr, input logic [31:0] alu,
                         input logic [4:0] irs1, irs2, input logic u1, u2,
                         input logic [31:0] mld, input logic fl);
        @(posedge clk);
        #1;
        ex_valid = v;   ex_rd = rd;   ex_rs1 = rs1;  ex_rs2 = rs2;
        ex_reg_write = we;  ex_mem_read = mr;  ex_alu_result = alu;
        id_rs1 = irs1;  id_rs2 = irs2;  id_use_rs1 = u1;  id_use_rs2 = u2;
        mem_load_data = mld;  flush = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0);
    endtask

    task automatic push_exp(input string name, input logic [5:0] mask,
                            input logic [1:0] efa, efb, input logic [31:0] eexm, emwb,
                            input logic [4:0] ewbrd, input logic ewbwe, input logic [31:0] ewbd,
                            input logic est, input logic [CW-1:0] ecnt);
        exp_t e;
        e.name = name;  e.cyc = cyc;  e.mask = mask;
        e.fa = efa;  e.fb = efb;  e.exm = eexm;  e.mwb = emwb;
        e.wb_rd = ewbrd;  e.wb_we = ewbwe;  e.wb_data = ewbd;
        e.stall = est;  e.cnt = ecnt;
        q.push_back(e);
    endtask

    task automatic check_exp(input exp_t e);
        int errs = 0;
        if (e.mask[0]) begin
            total++;
            if (fa !== e.fa || fb !== e.fb) begin
                bad++; errs++;
                $display("FAIL %s fwd: got A=%b B=%b want A=%b B=%b", e.name, fa, fb, e.fa, e.fb);
            end
        end
        if (e.mask[1]) begin
            total++;
            if (fwd_exm !== e.exm) begin
                bad++; errs++;
                $display("FAIL %s ex_mem: got %h want %h", e.name, fwd_exm, e.exm);
            end
        end
        if (e.mask[2]) begin
            total++;
            if (fwd_mwb !== e.mwb) begin
                bad++; errs++;
                $display("FAIL %s mem_wb: got %h want %h", e.name, fwd_mwb, e.mwb);
            end
        end
        if (e.mask[3]) begin
            total++;
            if (wb_rd !== e.wb_rd || wb_we !== e.wb_we || wb_data !== e.wb_data) begin
                bad++; errs++;
                $display("FAIL %s wb: got rd=%0d we=%b d=%h want rd=%0d we=%b d=%h",
                         e.name, wb_rd, wb_we, wb_data, e.wb_rd, e.wb_we, e.wb_data);
            end
        end
        if (e.mask[4]) begin
            total++;
            if (stall !== e.stall || bubble !== e.stall) begin
                bad++; errs++;
                $display("FAIL %s stall: got stall=%b bubble=%b want %b", e.name, stall, bubble, e.stall);
            end
        end
        if (e.mask[5]) begin
            total++;
            if (stall_cnt !== e.cnt) begin
                bad++; errs++;
                $display("FAIL %s stall_cnt: got %0d want %0d", e.name, stall_cnt, e.cnt);
            end
        end
        $display("txn %s cyc=%0d fa=%b fb=%b exm=%h mwb=%h stall=%b cnt=%0d errs=%0d",
                 e.name, e.cyc, fa, fb, fwd_exm, fwd_mwb, stall, stall_cnt, errs);
    endtask

    // Monitor: every negedge, consume the expectations registered for this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL %s stale: checked at cyc %0d want cyc %0d", e.name, cyc, e.cyc);
            end else begin
                check_exp(e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ex_valid = 0; ex_rd = 0; ex_rs1 = 0; ex_rs2 = 0; ex_reg_write = 0; ex_mem_read = 0;
        ex_alu_result = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        mem_load_data = 0; flush = 0;

        // Reset with a hazard pattern on the inputs: everything must still read zero.
        drive(1, 2, 2, 2, 1, 1, 32'h55, 2, 2, 1, 1, 32'h66, 0);
        push_exp("reset", M_ALL, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        idle();
        rst_n = 1'b1;
        idle();
        idle();

        // 1: EX/MEM forward to rs1
        drive(1, 1, 0, 0, 1, 0, 32'h15, 0, 0, 0, 0, 0, 0);
        drive(1, 2, 1, 3, 1, 0, 32'h20, 0, 0, 0, 0, 0, 0);
        push_exp("t1_exmem", M_FWD | M_EXM, 2'b10, 2'b00, 32'h15, 0, 0, 0, 0, 0, 0);
        idle();
        idle();

        // 2: MEM/WB forward to rs2 across a nop
        drive(1, 1, 0, 0, 1, 0, 32'h15, 0, 0, 0, 0, 0, 0);
        idle();
        drive(1, 4, 0, 1, 1, 0, 32'h44, 0, 0, 0, 0, 0, 0);
        push_exp("t2_memwb", M_FWD | M_MWB | M_WB, 2'b00, 2'b01, 0, 32'h15, 5'd1, 1'b1, 32'h15, 0, 0);
        idle();
        idle();

        // 3: youngest producer wins
        drive(1, 5, 0, 0, 1, 0, 32'h1, 0, 0, 0, 0, 0, 0);
        drive(1, 5, 0, 0, 1, 0, 32'h2, 0, 0, 0, 0, 0, 0);
        drive(1, 6, 5, 0, 1, 0, 32'h66, 0, 0, 0, 0, 0, 0);
        push_exp("t3_prio", M_FWD | M_EXM | M_MWB, 2'b10, 2'b00, 32'h2, 32'h1, 0, 0, 0, 0, 0);
        idle();
        idle();

        // 4: load-use stall, then MEM/WB forward of the loaded value
        drive(1, 2, 0, 0, 1, 1, 32'h100, 2, 2, 1, 1, 0, 0);
        push_exp("t4_stall", M_STL | M_CNT, 0, 0, 0, 0, 0, 0, 0, 1'b1, 0);
        drive(0, 0, 2, 0, 0, 0, 32'h0, 2, 2, 1, 1, 32'hDEAD, 0);
        push_exp("t4_bubble", M_STL | M_CNT | M_EXM | M_FWD, 2'b00, 2'b00, 32'h100, 0, 0, 0, 0, 1'b0, 1);
        drive(1, 3, 2, 2, 1, 0, 32'h1BC, 0, 0, 0, 0, 0, 0);
        push_exp("t4_use", M_FWD | M_MWB | M_WB | M_CNT, 2'b01, 2'b01, 0, 32'hDEAD, 5'd2, 1'b1, 32'hDEAD, 0, 1);
        idle();
        idle();

        // 5: flush suppresses the stall; x0 writes never forward
        drive(1, 2, 0, 0, 1, 1, 32'h200, 2, 0, 1, 0, 0, 1);
        push_exp("t5_flush", M_STL | M_CNT, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1);
        drive(1, 0, 0, 0, 1, 0, 32'h77, 0, 0, 0, 0, 0, 0);
        push_exp("t5_noclr", M_CNT | M_EXM, 0, 0, 32'h200, 0, 0, 0, 0, 0, 1);
        drive(1, 7, 0, 0, 1, 0, 32'h5, 0, 0, 0, 0, 0, 0);
        push_exp("t5_x0_exm", M_FWD, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 8, 0, 0, 1, 0, 32'h9, 0, 0, 0, 0, 0, 0);
        push_exp("t5_x0_mwb", M_FWD | M_WB, 2'b00, 2'b00, 0, 0, 5'd0, 1'b1, 32'h77, 0, 0);
        idle();
        idle();

        // Counter saturation: held hazard, count starts at 1
        for (int k = 0; k < 20; k++) begin
            int c;
            c = (1 + k > 15) ? 15 : 1 + k;
            drive(1, 2, 0, 0, 1, 1, 32'h300, 2, 2, 1, 1, 0, 0);
            push_exp("sat", M_STL | M_CNT, 0, 0, 0, 0, 0, 0, 0, 1'b1, CW'(c));
        end

        // 6: asynchronous reset in the middle of a load-use stall
        drive(1, 2, 0, 0, 1, 1, 32'h100, 2, 2, 1, 1, 32'hDEAD, 0);
        #1;
        rst_n = 1'b0;
        push_exp("t6_rst", M_ALL, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1'b0, 0);
        idle();
        rst_n = 1'b1;
        push_exp("t6_rel", M_WB | M_CNT | M_EXM, 0, 0, 0, 0, 0, 1'b0, 0, 0, 0);
        idle();
        push_exp("t6_nowb", M_WB | M_EXM, 0, 0, 0, 0, 0, 1'b0, 0, 0, 0);
        idle();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
